jk_excitation_driver: RTL and testbench
=======================================

# jk_excitation_driver

Drives an external WIDTH-bit bank of JK flip-flops to a requested next state by generating per-bit J/K excitation, then reads the bank back and checks it. It sits on the control side of the JK register bank: it accepts a request through a valid/ready handshake and computes the bank's target value. It then issues one cycle of J/K drive, samples the bank's Q outputs and reports done or mismatch. Failed updates are retried a bounded number of times.

## Interface
- WIDTH, 8: bank width in bits.
- RETRIES, 1: extra drive attempts after a failed check (0..7).
- clock  in  1  rising-edge clock, shared with the JK bank.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- req_data  in  WIDTH  LOAD target; ignored for other ops.
- q_in  in  WIDTH  bank Q feedback.
- j_out  out  WIDTH  registered J drive to bank.
- k_out  out  WIDTH  registered K drive to bank.
- done  out  1  one-cycle pulse when a request completes, pass or fail.
- mismatch  out  1  registered with done; set when the final check failed.
- err_count  out  8  saturating count of failed final checks.

## Operation
- The FSM has three states: IDLE, DRIVE, CHECK.
- IDLE:
  - req_ready=1; j_out=k_out=0, which is the bank hold state.
  - On req_valid&req_ready, latch target and go to DRIVE.
  - Target per op: LOAD = req_data. INC = q_in+1, mod 2^WIDTH. DEC = q_in−1, mod 2^WIDTH. CLEAR = 0.
  - q_in is sampled on the accept edge.
- DRIVE:
  - j_out/k_out come from the per-bit excitation of (q_in, target), registered so they are valid for exactly one cycle.
  - Next state is CHECK.
- Excitation, default policy; don't-cares resolve to 0:
  - 0→0: J=0, K=0.
  - 0→1: J=1, K=0.
  - 1→0: J=0, K=1.
  - 1→1: J=0, K=0.
- CHECK:
  - j_out=k_out=0.
  - Compare q_in to target.
  - On match: done=1, mismatch=0, go to IDLE.
  - On miss with retries_left>0: decrement retries_left and go to DRIVE, recomputing excitation from the current q_in.
  - On miss with retries_left=0: done=1, mismatch=1, err_count+1 saturating at 255, go to IDLE.
- retries_left is loaded with RETRIES on accept.
- Reset, including mid-DRIVE or mid-CHECK:
  - Return to IDLE.
  - j_out=k_out=0, done=0, mismatch=0, err_count=0, target=0, retries_left=0.
  - No partial drive pulse survives reset.
- A request held valid while not ready is not accepted, and req_data/req_op changes during that time have no effect.

## Timing
- Accept at edge E0.
- j_out/k_out are valid in cycle E0..E1; the bank captures on E1.
- q_in is compared at edge E2; done/mismatch are high in cycle E2..E3.
- A clean pass therefore takes 3 edges from accept to the done pulse.
- Each retry adds 2 cycles.
- req_ready returns high in the same cycle as done, so back-to-back accept is possible at E3.
- mismatch holds its value until the next done.

## Configuration
- JK_TOGGLE_PREF_EN:
  - Defined: transitions 0→1 and 1→0 drive J=1, K=1 (toggle); the hold cases are unchanged.
  - Undefined: the default policy above.
- The resulting bank state is identical under both policies; only the drive pattern differs.

## Structure
- Package jk_drv_pkg holds:
  - op enum (OP_LOAD, OP_INC, OP_DEC, OP_CLEAR);
  - state enum (ST_IDLE, ST_DRIVE, ST_CHECK);
  - ERR_MAX=8'hFF.
- Sub-module jk_excite_cell: a one-bit combinational map (q, t) → (j, k), with the macro policy applied inside it; it is instantiated WIDTH times.
- The bench connects j_out/k_out/q_in to a WIDTH-bit JK bank model that has a fault-inject input.

## Test plan
- Bank at 8'h00; LOAD 8'hA5 → j_out=8'hA5, k_out=8'h00 for one cycle; done at E2 with mismatch=0; q_in=8'hA5.
- Bank at 8'hFF; INC → target 8'h00 (wrap); k_out=8'hFF; done, mismatch=0. With JK_TOGGLE_PREF_EN, j_out=k_out=8'hFF.
- Bank at 8'h00; DEC → q_in=8'hFF; then CLEAR → q_in=8'h00; both pass.
- Bank stuck-at-0 on bit 3, RETRIES=1; LOAD 8'h08 → two DRIVE pulses, done at E4, mismatch=1, err_count=1.
- Assert reset low during DRIVE → the next cycle shows j_out=k_out=0, IDLE, req_ready=1, no done pulse, err_count=0.
- req_valid held through busy cycles with changing req_data → only the first request is accepted; the second is accepted on the cycle done is high.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared types for the JK excitation driver: request opcodes, FSM states, error ceiling.
// Pure declarations, no logic, no latency.
// No flow control of its own.
package jk_drv_pkg;

  // Request opcodes as carried on req_op
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Driver FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10
  } state_e;

  // err_count stops here instead of wrapping
  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/jk_excite_cell.sv
// One-bit JK excitation map (q, t) -> (j, k); build option JK_TOGGLE_PREF_EN.
// Purely combinational, zero latency.
// No handshake; consumer registers the result.
module jk_excite_cell (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

`ifdef JK_TOGGLE_PREF_EN
  // Any change of state is driven as a toggle; holds stay at J=K=0
  assign j = q ^ t;
  assign k = q ^ t;
`else
  // Set only on a rising bit, reset only on a falling bit; don't-cares read as 0
  assign j = ~q & t;
  assign k = q & ~t;
`endif

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to a requested value, reads it back, retries on a miss.
// Accept to done: 3 edges on a clean pass, +2 edges per retry.
// req_ready only in IDLE; one request in flight, inputs ignored while busy.
import jk_drv_pkg::*;

module jk_excitation_driver #(
  parameter int WIDTH   = 8,
  parameter int RETRIES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count
);

  localparam logic [2:0] RETRY_INIT = 3'(RETRIES);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] target, target_nxt;
  logic [2:0]       retries_left, retries_nxt;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic             done_nxt, mismatch_nxt;
  logic [7:0]       err_nxt;

  op_e              op;
  logic [WIDTH-1:0] req_target;
  logic [WIDTH-1:0] exc_t, exc_j, exc_k;
  logic             accept;

  assign op        = op_e'(req_op);
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // Target for an incoming request, relative to the bank value seen right now
  always_comb begin
    req_target = '0;
    case (op)
      OP_LOAD:  req_target = req_data;
      OP_INC:   req_target = q_in + 1'b1;
      OP_DEC:   req_target = q_in - 1'b1;
      OP_CLEAR: req_target = '0;
      default:  req_target = '0;
    endcase
  end

  // In IDLE the excitation feeds the first drive of a new request; otherwise a retry
  assign exc_t = (state == ST_IDLE) ? req_target : target;

  for (genvar b = 0; b < WIDTH; b++) begin : g_cell
    jk_excite_cell u_cell (
      .q (q_in[b]),
      .t (exc_t[b]),
      .j (exc_j[b]),
      .k (exc_k[b])
    );
  end

  // Next-state and registered-output decisions; J/K default to the hold pattern
  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    retries_nxt  = retries_left;
    j_nxt        = '0;
    k_nxt        = '0;
    done_nxt     = 1'b0;
    mismatch_nxt = mismatch;
    err_nxt      = err_count;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          target_nxt  = req_target;
          retries_nxt = RETRY_INIT;
          j_nxt       = exc_j;
          k_nxt       = exc_k;
          state_nxt   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // The bank captures the drive on this edge; release to hold afterwards
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (q_in == target) begin
          done_nxt     = 1'b1;
          mismatch_nxt = 1'b0;
          state_nxt    = ST_IDLE;
        end else if (retries_left != 3'd0) begin
          // Re-drive from what the bank actually holds now
          retries_nxt = retries_left - 3'd1;
          j_nxt       = exc_j;
          k_nxt       = exc_k;
          state_nxt   = ST_DRIVE;
        end else begin
          done_nxt     = 1'b1;
          mismatch_nxt = 1'b1;
          err_nxt      = (err_count == ERR_MAX) ? ERR_MAX : err_count + 8'd1;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears any drive pulse in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      target       <= '0;
      retries_left <= 3'd0;
      j_out        <= '0;
      k_out        <= '0;
      done         <= 1'b0;
      mismatch     <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      retries_left <= retries_nxt;
      j_out        <= j_nxt;
      k_out        <= k_nxt;
      done         <= done_nxt;
      mismatch     <= mismatch_nxt;
      err_count    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench: JK bank model with stuck-at-0 injection, directed plus random requests.
// Expected values come from a word-level model of target, drive pattern and bank result.
// Inputs driven #1 after the rising edge, outputs sampled there too.
import jk_drv_pkg::*;

module tb_jk_excitation_driver;

  localparam int WIDTH   = 8;
  localparam int RETRIES = 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [WIDTH-1:0] req_data = '0;
  logic [WIDTH-1:0] j_out, k_out;
  logic             done, mismatch;
  logic [7:0]       err_count;

  // JK bank model state and its controls
  logic [WIDTH-1:0] bank_q = '0;
  logic [WIDTH-1:0] stuck = '0;
  logic             bank_load_en = 1'b0;
  logic [WIDTH-1:0] bank_load_val = '0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] errc = 8'd0;
  logic       mism_exp = 1'b0;

  always #5 clock = ~clock;

  jk_excitation_driver #(.WIDTH(WIDTH), .RETRIES(RETRIES)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .q_in      (bank_q),
    .j_out     (j_out),
    .k_out     (k_out),
    .done      (done),
    .mismatch  (mismatch),
    .err_count (err_count)
  );

  // JK bank: Q+ = J.~Q | ~K.Q per bit, with stuck-at-0 bits forced low
  always @(posedge clock) begin
    if (bank_load_en) bank_q <= bank_load_val & ~stuck;
    else              bank_q <= ((j_out & ~bank_q) | (~k_out & bank_q)) & ~stuck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_target(input logic [1:0] op, input logic [7:0] d,
                                            input logic [7:0] q);
    int v;
    case (op)
      2'b00:   v = int'(d);
      2'b01:   v = (int'(q) + 1) % 256;
      2'b10:   v = (int'(q) + 255) % 256;
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  // Bits needing to rise get J, bits needing to fall get K (toggle build: both)
  function automatic logic [7:0] ref_j(input logic [7:0] q, input logic [7:0] t);
`ifdef JK_TOGGLE_PREF_EN
    return q ^ t;
`else
    return t & ~q;
`endif
  endfunction

  function automatic logic [7:0] ref_k(input logic [7:0] q, input logic [7:0] t);
`ifdef JK_TOGGLE_PREF_EN
    return q ^ t;
`else
    return q & ~t;
`endif
  endfunction

  task automatic set_bank(input logic [7:0] v);
    bank_load_en  = 1'b1;
    bank_load_val = v;
    @(posedge clock); #1;
    bank_load_en  = 1'b0;
  endtask

  // One full request from IDLE to its done pulse, checked cycle by cycle
  task automatic run_req(input logic [1:0] op, input logic [7:0] data);
    logic [7:0] q, tgt;
    int left;
    bit fin;
    q   = bank_q;
    tgt = ref_target(op, data, q);
    req_valid = 1'b1; req_op = op; req_data = data;
    chk("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_data = 8'($urandom);
    left = RETRIES;
    fin  = 1'b0;
    while (!fin) begin
      chk("j_drive", 32'(j_out), 32'(ref_j(q, tgt)));
      chk("k_drive", 32'(k_out), 32'(ref_k(q, tgt)));
      chk("ready_busy", 32'(req_ready), 32'd0);
      chk("done_drive", 32'(done), 32'd0);
      chk("mism_hold", 32'(mismatch), 32'(mism_exp));
      @(posedge clock); #1;
      chk("j_check", 32'(j_out), 32'd0);
      chk("k_check", 32'(k_out), 32'd0);
      chk("done_check", 32'(done), 32'd0);
      q = tgt & ~stuck;
      chk("bank_q", 32'(bank_q), 32'(q));
      @(posedge clock); #1;
      if (q == tgt) begin
        mism_exp = 1'b0;
        chk("done_pass", 32'(done), 32'd1);
        chk("mism_pass", 32'(mismatch), 32'd0);
        fin = 1'b1;
      end else if (left > 0) begin
        left--;
        chk("done_retry", 32'(done), 32'd0);
      end else begin
        mism_exp = 1'b1;
        if (errc != 8'hFF) errc = errc + 8'd1;
        chk("done_fail", 32'(done), 32'd1);
        chk("mism_fail", 32'(mismatch), 32'd1);
        fin = 1'b1;
      end
    end
    chk("err_count", 32'(err_count), 32'(errc));
    chk("ready_done", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] q1;
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_j", 32'(j_out), 32'd0);
    chk("rst_k", 32'(k_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mism", 32'(mismatch), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed: load, wrap on INC, DEC then CLEAR
    set_bank(8'h00);
    run_req(OP_LOAD, 8'hA5);
    chk("load_a5", 32'(bank_q), 32'hA5);
    set_bank(8'hFF);
    run_req(OP_INC, 8'h5A);
    chk("inc_wrap", 32'(bank_q), 32'h00);
    set_bank(8'h00);
    run_req(OP_DEC, 8'h12);
    chk("dec_wrap", 32'(bank_q), 32'hFF);
    run_req(OP_CLEAR, 8'h77);
    chk("clear", 32'(bank_q), 32'h00);

    // Stuck-at-0 on bit 3: two drives, then a reported failure
    stuck = 8'h08;
    set_bank(8'h00);
    run_req(OP_LOAD, 8'h08);
    chk("stuck_err1", 32'(err_count), 32'd1);
    stuck = 8'h00;

    // Random requests with occasional stuck bits
    for (int i = 0; i < 60; i++) begin
      stuck = ($urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 1) == 0) set_bank(8'($urandom));
      run_req(2'($urandom), 8'($urandom));
    end

    // Saturation of err_count
    stuck = 8'h01;
    set_bank(8'h00);
    for (int i = 0; i < 260; i++) run_req(OP_LOAD, 8'h01);
    chk("err_sat", 32'(err_count), 32'hFF);
    stuck = 8'h00;

    // Reset in the middle of DRIVE
    set_bank(8'h00);
    req_valid = 1'b1; req_op = OP_LOAD; req_data = 8'h5A;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("mid_drive_j", 32'(j_out), 32'(ref_j(8'h00, 8'h5A)));
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_j", 32'(j_out), 32'd0);
    chk("mid_rst_k", 32'(k_out), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    chk("mid_rst_mism", 32'(mismatch), 32'd0);
    reset = 1'b1;
    errc = 8'd0;
    mism_exp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("post_rst_nodone", 32'(done), 32'd0);
      chk("post_rst_j", 32'(j_out), 32'd0);
    end

    // req_valid held through busy cycles with changing payload
    set_bank(8'h81);
    req_valid = 1'b1; req_op = OP_LOAD; req_data = 8'h3C;
    @(posedge clock); #1;
    chk("hold_j0", 32'(j_out), 32'(ref_j(8'h81, 8'h3C)));
    for (int i = 0; i < 2; i++) begin
      req_op = 2'($urandom); req_data = 8'($urandom);
      chk("hold_ready", 32'(req_ready), 32'd0);
      @(posedge clock); #1;
    end
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_ready_done", 32'(req_ready), 32'd1);
    chk("hold_bank1", 32'(bank_q), 32'h3C);
    q1 = bank_q;
    req_op = OP_LOAD; req_data = 8'hC3;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("b2b_j", 32'(j_out), 32'(ref_j(q1, 8'hC3)));
    chk("b2b_k", 32'(k_out), 32'(ref_k(q1, 8'hC3)));
    chk("b2b_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_bank", 32'(bank_q), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
